adc78h90_scanner: RTL and testbench

ADC78H90_SCANNER -- requirements
Module: adc78h90_scanner

---
 rtl/adc78h90_scanner.sv | 162 ++++++++++++++++
 tb/tb_adc78h90_scanner.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc78h90_scanner.sv
// adc78h90_scanner: scans ADC78H90 channels 0..NCH-1 over SPI.
// Each frame is 16 SCLK periods with nADCCS low. The control word carries the
// next address. The result read in a frame belongs to the address sent in the
// previous frame.
// Output handshake: data_valid is a one-clk strobe with no back-pressure.
// data_chan and data are valid in that clk and hold until the next strobe.
module adc78h90_scanner #(
    parameter int SCLK_HALF = 4,
    parameter int NCH       = 4,
    parameter int GAP       = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    output logic        nADCCS,
    output logic        ADCCLK,
    output logic        ADCMOSI,
    input  logic        ADCMISO,
    output logic        data_valid,
    output logic [2:0]  data_chan,
    output logic [11:0] data,
    output logic        busy,
    output logic [1:0]  state_dbg
);

    localparam logic [7:0] DIV_LAST  = 8'(SCLK_HALF - 1);
    localparam logic [7:0] GAP_LAST  = 8'(GAP - 1);
    localparam logic [2:0] ADDR_LAST = 3'(NCH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FRAME = 2'd1,
        GAPW  = 2'd2
    } state_t;

    state_t      state, state_nx;
    logic [7:0]  div_cnt;
    logic [7:0]  gap_cnt;
    logic [4:0]  half_idx;
    logic [4:0]  half_nx;
    logic [2:0]  addr;
    logic [2:0]  prev_addr;
    logic [2:0]  pend_chan;
    logic [15:0] shift;
    logic [15:0] ctrl_word;
    logic        primed;
    logic        pend_out;
    logic        half_end;
    logic        frame_end;
    logic        gap_end;
    logic        start_frame;
    logic        go_idle;
    logic        unused_lead;

    // The ADC's four leading bits are shifted in but never used.
    assign unused_lead = ^shift[15:12];

    assign busy      = (state != IDLE);
    assign state_dbg = state;

    // Frame timing decodes and next-state selection.
    always_comb begin
        half_end    = (state == FRAME) && (div_cnt == DIV_LAST);
        frame_end   = half_end && (half_idx == 5'd31);
        gap_end     = (state == GAPW) && (gap_cnt == GAP_LAST);
        start_frame = enable && ((state == IDLE) || gap_end);
        go_idle     = gap_end && !enable;
        half_nx     = half_idx + 5'd1;
        ctrl_word   = {2'b00, addr, 11'b0};
        state_nx    = state;
        case (state)
            IDLE:    if (enable) state_nx = FRAME;
            FRAME:   if (frame_end) state_nx = GAPW;
            GAPW:    if (gap_end) state_nx = enable ? FRAME : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // SPI waveform generation, MISO capture, address sequencing and result strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nADCCS     <= 1'b1;
            ADCCLK     <= 1'b1;
            ADCMOSI    <= 1'b0;
            data_valid <= 1'b0;
            data       <= 12'd0;
            data_chan  <= 3'd0;
            div_cnt    <= 8'd0;
            gap_cnt    <= 8'd0;
            half_idx   <= 5'd0;
            addr       <= 3'd0;
            prev_addr  <= 3'd0;
            pend_chan  <= 3'd0;
            shift      <= 16'd0;
            primed     <= 1'b0;
            pend_out   <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            pend_out   <= 1'b0;
            if (pend_out) begin
                data_valid <= 1'b1;
                data       <= shift[11:0];
                data_chan  <= pend_chan;
            end

            if (start_frame) begin
                nADCCS   <= 1'b0;
                ADCCLK   <= 1'b1;
                div_cnt  <= 8'd0;
                half_idx <= 5'd0;
            end

            if (state == FRAME) begin
                if (!half_end) begin
                    div_cnt <= div_cnt + 8'd1;
                end else if (frame_end) begin
                    // The final rising edge coincides with nADCCS going high.
                    nADCCS    <= 1'b1;
                    ADCCLK    <= 1'b1;
                    shift     <= {shift[14:0], ADCMISO};
                    gap_cnt   <= 8'd0;
                    pend_out  <= primed;
                    pend_chan <= prev_addr;
                    prev_addr <= addr;
                    addr      <= (addr == ADDR_LAST) ? 3'd0 : addr + 3'd1;
                    primed    <= 1'b1;
                end else begin
                    div_cnt  <= 8'd0;
                    half_idx <= half_nx;
                    ADCCLK   <= ~half_nx[0];
                    if (half_nx[0]) begin
                        // Falling edge: present the next control bit.
                        ADCMOSI <= ctrl_word[4'd15 - half_nx[4:1]];
                    end else begin
                        // Rising edge: capture the ADC output bit.
                        shift <= {shift[14:0], ADCMISO};
                    end
                end
            end

            if (state == GAPW) begin
                gap_cnt <= gap_cnt + 8'd1;
            end

            // Leaving the scan restarts at address 0 with a discarded first frame.
            if (go_idle) begin
                addr   <= 3'd0;
                primed <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_adc78h90_scanner.sv
// tb_adc78h90_scanner: directed scoreboard bench for adc78h90_scanner.
// Two instances: defaults (SCLK_HALF=4, NCH=4, GAP=8), and a single-channel
// instance (SCLK_HALF=2, NCH=1, GAP=1). A shared ADC model and monitor
// follow whichever instance `sel` picks.
module tb_adc78h90_scanner;

    logic clk = 1'b0;
    logic rst_n;
    logic enable0, enable1;
    logic adc_miso;

    logic        ncs0, sclk0, mosi0, dv0, busy0;
    logic [2:0]  chan0;
    logic [11:0] data0;
    logic [1:0]  st0;
    logic        ncs1, sclk1, mosi1, dv1, busy1;
    logic [2:0]  chan1;
    logic [11:0] data1;
    logic [1:0]  st1;

    int total = 0;
    int bad   = 0;
    int sel   = 0;
    int frame_no = 0;

    logic [14:0] exp_q[$];
    logic [2:0]  exp_addr_q[$];

    // Clock generation.
    always #5 clk = ~clk;

    adc78h90_scanner #(.SCLK_HALF(4), .NCH(4), .GAP(8)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .enable(enable0),
        .nADCCS(ncs0), .ADCCLK(sclk0), .ADCMOSI(mosi0), .ADCMISO(adc_miso),
        .data_valid(dv0), .data_chan(chan0), .data(data0),
        .busy(busy0), .state_dbg(st0)
    );

    adc78h90_scanner #(.SCLK_HALF(2), .NCH(1), .GAP(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .enable(enable1),
        .nADCCS(ncs1), .ADCCLK(sclk1), .ADCMOSI(mosi1), .ADCMISO(adc_miso),
        .data_valid(dv1), .data_chan(chan1), .data(data1),
        .busy(busy1), .state_dbg(st1)
    );

    logic        m_cs, m_sc, m_mosi, m_dv, m_busy;
    logic [2:0]  m_chan;
    logic [11:0] m_data;
    assign m_cs   = (sel == 1) ? ncs1  : ncs0;
    assign m_sc   = (sel == 1) ? sclk1 : sclk0;
    assign m_mosi = (sel == 1) ? mosi1 : mosi0;
    assign m_dv   = (sel == 1) ? dv1   : dv0;
    assign m_busy = (sel == 1) ? busy1 : busy0;
    assign m_chan = (sel == 1) ? chan1 : chan0;
    assign m_data = (sel == 1) ? data1 : data0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ADC conversion word (leading nibble + 12-bit result) per channel.
    function automatic logic [15:0] adc_word(input int s, input logic [2:0] a);
        if (s == 1) return 16'hFFFF;
        case (a)
            3'd0:    return 16'h0A5C;
            3'd1:    return 16'h0123;
            3'd2:    return 16'h07FF;
            3'd3:    return 16'h0001;
            default: return 16'h0000;
        endcase
    endfunction

    // ADC model and monitor.
    logic        prev_cs = 1'b1;
    logic        prev_sc = 1'b1;
    logic        in_frame = 1'b0;
    int          rise_n, fall_n, low_cnt;
    logic [15:0] ctrl_sh, word;
    logic [2:0]  adc_addr = 3'd0;
    logic [2:0]  ea;

    // Sampled on the falling clk edge, away from the DUT's active edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            in_frame = 1'b0;
        end else begin
            if (prev_cs && !m_cs) begin
                in_frame = 1'b1;
                rise_n   = 0;
                fall_n   = 0;
                low_cnt  = 0;
                ctrl_sh  = 16'd0;
                word     = adc_word(sel, adc_addr);
                frame_no++;
            end
            if (in_frame) begin
                if (!m_cs) low_cnt++;
                if (prev_sc && !m_sc && fall_n < 16) begin
                    adc_miso = word[15 - fall_n];
                    fall_n++;
                end
                if (!prev_sc && m_sc) begin
                    ctrl_sh = {ctrl_sh[14:0], m_mosi};
                    rise_n++;
                end
                if (!prev_cs && m_cs) begin
                    in_frame = 1'b0;
                    check("sclk_rises", rise_n, 16);
                    check("cs_low_clks", low_cnt, (sel == 1) ? 64 : 128);
                    if (exp_addr_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL ctrl_word: unexpected frame, got 0x%0h", ctrl_sh);
                    end else begin
                        ea = exp_addr_q.pop_front();
                        check("ctrl_word", ctrl_sh, {16'd0, 2'b00, ea, 11'b0});
                    end
                    adc_addr = ctrl_sh[13:11];
                end
            end
            if (m_dv) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL strobe: unexpected chan=%0d data=0x%0h", m_chan, m_data);
                end else begin
                    check("strobe", {17'd0, m_chan, m_data}, {17'd0, exp_q.pop_front()});
                end
            end
        end
        prev_cs = m_cs;
        prev_sc = m_sc;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_frames(input int target, input int budget);
        int n;
        n = 0;
        while (frame_no < target && n < budget) begin
            tick();
            n++;
        end
        check("frame_start_wait", (frame_no >= target), 1);
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (m_busy && n < budget) begin
            tick();
            n++;
        end
        check("idle_wait", m_busy, 0);
    endtask

    // Watchdog.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    // Directed stimulus.
    initial begin
        int base, t, t_rise;
        logic pcs;
        rst_n = 1'b0; enable0 = 1'b0; enable1 = 1'b0; adc_miso = 1'b0; sel = 0;
        repeat (3) tick();
        check("rst_ncs", ncs0, 1);
        check("rst_sclk", sclk0, 1);
        check("rst_mosi", mosi0, 0);
        check("rst_dv", dv0, 0);
        check("rst_data", data0, 0);
        check("rst_chan", chan0, 0);
        check("rst_busy", busy0, 0);
        check("rst_ncs1", ncs1, 1);
        rst_n = 1'b1;
        repeat (20) tick();
        check("no_frame_without_enable", frame_no, 0);

        // Continuous scan of four channels.
        base = frame_no;
        exp_addr_q.push_back(3'd0); exp_addr_q.push_back(3'd1);
        exp_addr_q.push_back(3'd2); exp_addr_q.push_back(3'd3);
        exp_addr_q.push_back(3'd0); exp_addr_q.push_back(3'd1);
        exp_q.push_back({3'd0, 12'hA5C}); exp_q.push_back({3'd1, 12'h123});
        exp_q.push_back({3'd2, 12'h7FF}); exp_q.push_back({3'd3, 12'h001});
        exp_q.push_back({3'd0, 12'hA5C});
        enable0 = 1'b1;
        wait_frames(base + 6, 2000);
        repeat (5) tick();
        enable0 = 1'b0;
        wait_idle(2000);
        repeat (3) tick();
        check("scan_strobes_left", exp_q.size(), 0);
        check("scan_frames_left", exp_addr_q.size(), 0);

        // Enable dropped mid-frame 2; frame completes, then idle after GAP.
        base = frame_no;
        exp_addr_q.push_back(3'd0); exp_addr_q.push_back(3'd1); exp_addr_q.push_back(3'd2);
        exp_q.push_back({3'd0, 12'hA5C}); exp_q.push_back({3'd1, 12'h123});
        enable0 = 1'b1;
        wait_frames(base + 3, 2000);
        repeat (9) tick();
        enable0 = 1'b0;
        t = 0; t_rise = 0; pcs = ncs0;
        while (busy0 && t < 1000) begin
            tick();
            t++;
            if (!pcs && ncs0) t_rise = t;
            pcs = ncs0;
        end
        check("busy_after_drop", busy0, 0);
        check("gap_to_idle", t - t_rise, 8);
        base = frame_no;
        repeat (200) tick();
        check("no_activity_frames", frame_no, base);
        check("no_activity_ncs", ncs0, 1);
        check("drop_strobes_left", exp_q.size(), 0);
        check("drop_frames_left", exp_addr_q.size(), 0);

        // Reset at clk 50 of a frame.
        base = frame_no;
        exp_addr_q.push_back(3'd0);
        enable0 = 1'b1;
        wait_frames(base + 2, 2000);
        repeat (49) tick();
        rst_n = 1'b0;
        #1;
        check("arst_ncs", ncs0, 1);
        check("arst_sclk", sclk0, 1);
        check("arst_mosi", mosi0, 0);
        check("arst_busy", busy0, 0);
        check("arst_dv", dv0, 0);
        check("arst_data", data0, 0);
        check("arst_chan", chan0, 0);
        enable0 = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (50) tick();
        check("post_reset_no_frame", frame_no, base + 2);
        check("reset_strobes_left", exp_q.size(), 0);
        check("reset_frames_left", exp_addr_q.size(), 0);

        // Re-enable: restart at address 0 with the first result discarded.
        base = frame_no;
        exp_addr_q.push_back(3'd0); exp_addr_q.push_back(3'd1);
        exp_q.push_back({3'd0, 12'hA5C});
        enable0 = 1'b1;
        wait_frames(base + 2, 2000);
        repeat (10) tick();
        enable0 = 1'b0;
        wait_idle(2000);
        repeat (20) tick();
        check("restart_strobes_left", exp_q.size(), 0);
        check("restart_frames_left", exp_addr_q.size(), 0);
        check("hold_data", data0, 12'hA5C);
        check("hold_chan", chan0, 0);

        // Single channel, leading ADC bits set.
        sel = 1;
        repeat (2) tick();
        base = frame_no;
        for (int i = 0; i < 4; i++) exp_addr_q.push_back(3'd0);
        for (int i = 0; i < 3; i++) exp_q.push_back({3'd0, 12'hFFF});
        enable1 = 1'b1;
        wait_frames(base + 4, 2000);
        repeat (3) tick();
        enable1 = 1'b0;
        wait_idle(2000);
        repeat (5) tick();
        check("nch1_strobes_left", exp_q.size(), 0);
        check("nch1_frames_left", exp_addr_q.size(), 0);
        check("nch1_data", data1, 12'hFFF);
        check("nch1_chan", chan1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
